// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit
// Pipeline hazard controller for the 5-stage RV32IM core. It decides each cycle whether
// PC, IF/ID and ID/EX advance, hold, take a bubble or are flushed. It also sequences the
// fixed-latency M-extension unit in EX: start pulse, occupancy count and release.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   id_rs1/rs2_addr_i     source registers of the instruction in ID
//   id_uses_rs1/rs2_i     ID instruction actually reads rs1 / rs2
//   ex_mem_read_i         instruction in EX is a load
//   ex_rd_addr_i          destination register of the instruction in EX
//   ex_is_muldiv_i        instruction in EX is MUL/DIV/REM
//   ex_redirect_i         EX resolved a control-flow redirect
//   pc_stall_o, if_id_stall_o, if_id_flush_o        front-end controls
//   id_ex_hold_o, id_ex_bubble_o, id_ex_flush_o     ID/EX register controls
//   ex_mem_bubble_o       load NOP into EX/MEM while the M-unit is busy
//   md_start_o, md_busy_o M-unit start pulse and occupancy flag
//   stall_cycles_o, flush_count_o   statistics counters
//
// Build option: define HAZARD_STATS_EN to build the statistics counters; otherwise both
// counter outputs are tied to zero.

module hazard_ctrl_unit #(
   parameter int unsigned MD_LATENCY = 4,
   parameter int unsigned CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs1_addr_i,
   input  logic [4:0]       id_rs2_addr_i,
   input  logic             id_uses_rs1_i,
   input  logic             id_uses_rs2_i,
   input  logic             ex_mem_read_i,
   input  logic [4:0]       ex_rd_addr_i,
   input  logic             ex_is_muldiv_i,
   input  logic             ex_redirect_i,
   output logic             pc_stall_o,
   output logic             if_id_stall_o,
   output logic             if_id_flush_o,
   output logic             id_ex_hold_o,
   output logic             id_ex_bubble_o,
   output logic             id_ex_flush_o,
   output logic             ex_mem_bubble_o,
   output logic             md_start_o,
   output logic             md_busy_o,
   output logic [CNT_W-1:0] stall_cycles_o,
   output logic [CNT_W-1:0] flush_count_o
);

   typedef enum logic [0:0] {StRun, StMdBusy} state_e;

   state_e     state_q, state_d;
   logic [7:0] md_cnt_q, md_cnt_d;
   logic       load_use;

   assign load_use = ex_mem_read_i && (ex_rd_addr_i != 5'd0) &&
                     ((id_uses_rs1_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                      (id_uses_rs2_i && (id_rs2_addr_i == ex_rd_addr_i)));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StRun;
         md_cnt_q <= 8'd0;
      end else begin
         state_q  <= state_d;
         md_cnt_q <= md_cnt_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      md_cnt_d        = md_cnt_q;
      pc_stall_o      = 1'b0;
      if_id_stall_o   = 1'b0;
      if_id_flush_o   = 1'b0;
      id_ex_hold_o    = 1'b0;
      id_ex_bubble_o  = 1'b0;
      id_ex_flush_o   = 1'b0;
      ex_mem_bubble_o = 1'b0;
      md_start_o      = 1'b0;
      md_busy_o       = 1'b0;

      // While in reset every output stays low; the register resets on the edge.
      if (rst_n) begin
         unique case (state_q)
            StRun: begin
               if (ex_redirect_i) begin
                  if_id_flush_o = 1'b1;
                  id_ex_flush_o = 1'b1;
               end else if (ex_is_muldiv_i) begin
                  md_start_o      = 1'b1;
                  pc_stall_o      = 1'b1;
                  if_id_stall_o   = 1'b1;
                  id_ex_hold_o    = 1'b1;
                  ex_mem_bubble_o = 1'b1;
                  md_cnt_d        = 8'(MD_LATENCY - 1);
                  state_d         = StMdBusy;
               end else if (load_use) begin
                  pc_stall_o     = 1'b1;
                  if_id_stall_o  = 1'b1;
                  id_ex_bubble_o = 1'b1;
               end
            end
            StMdBusy: begin
               // Redirect and load-use are ignored here: the front end is already held.
               md_busy_o = 1'b1;
               if (md_cnt_q > 8'd1) begin
                  pc_stall_o      = 1'b1;
                  if_id_stall_o   = 1'b1;
                  id_ex_hold_o    = 1'b1;
                  ex_mem_bubble_o = 1'b1;
                  md_cnt_d        = md_cnt_q - 8'd1;
               end else begin
                  // Release cycle: the result leaves EX, muldiv input not re-sampled.
                  state_d  = StRun;
                  md_cnt_d = 8'd0;
               end
            end
            default: state_d = StRun;
         endcase
      end
   end

`ifdef HAZARD_STATS_EN
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   // if_id_flush_o is only raised for an accepted redirect.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (pc_stall_o)    stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (if_id_flush_o) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign stall_cycles_o = stall_cnt_q;
   assign flush_count_o  = flush_cnt_q;
`else
   assign stall_cycles_o = '0;
   assign flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit. Two instances (MD_LATENCY 4 and 2) share the
// stimulus; a behavioural model tracks which EX cycle of a MUL/DIV occupancy is current
// and is compared against both on every falling edge. Directed checks pin the model.

module tb_hazard_ctrl_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  rs1, rs2, rd;
   logic        u1, u2, mr, md, rdr;

   logic        pc_stall1, if_id_stall1, if_id_flush1, id_ex_hold1, id_ex_bubble1;
   logic        id_ex_flush1, ex_mem_bubble1, md_start1, md_busy1;
   logic [31:0] stall_cnt1, flush_cnt1;
   logic        pc_stall2, if_id_stall2, if_id_flush2, id_ex_hold2, id_ex_bubble2;
   logic        id_ex_flush2, ex_mem_bubble2, md_start2, md_busy2;
   logic [31:0] stall_cnt2, flush_cnt2;
   logic [8:0]  o1, o2;

   int checks = 0;
   int errors = 0;
   int n_start = 0;
   int n_stall = 0;

   // Model state: 0 = not occupied by MUL/DIV, k>=2 = k-th EX cycle of the occupancy.
   int          ph1 = 0;
   int          ph2 = 0;
   logic [31:0] m_stall = 0;
   logic [31:0] m_flush = 0;
   logic [8:0]  e_pos;

   always #5 clk = ~clk;

   hazard_ctrl_unit #(.MD_LATENCY(4), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2), .id_uses_rs1_i(u1), .id_uses_rs2_i(u2),
      .ex_mem_read_i(mr), .ex_rd_addr_i(rd), .ex_is_muldiv_i(md), .ex_redirect_i(rdr),
      .pc_stall_o(pc_stall1), .if_id_stall_o(if_id_stall1), .if_id_flush_o(if_id_flush1),
      .id_ex_hold_o(id_ex_hold1), .id_ex_bubble_o(id_ex_bubble1),
      .id_ex_flush_o(id_ex_flush1), .ex_mem_bubble_o(ex_mem_bubble1),
      .md_start_o(md_start1), .md_busy_o(md_busy1),
      .stall_cycles_o(stall_cnt1), .flush_count_o(flush_cnt1)
   );

   hazard_ctrl_unit #(.MD_LATENCY(2), .CNT_W(32)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2), .id_uses_rs1_i(u1), .id_uses_rs2_i(u2),
      .ex_mem_read_i(mr), .ex_rd_addr_i(rd), .ex_is_muldiv_i(md), .ex_redirect_i(rdr),
      .pc_stall_o(pc_stall2), .if_id_stall_o(if_id_stall2), .if_id_flush_o(if_id_flush2),
      .id_ex_hold_o(id_ex_hold2), .id_ex_bubble_o(id_ex_bubble2),
      .id_ex_flush_o(id_ex_flush2), .ex_mem_bubble_o(ex_mem_bubble2),
      .md_start_o(md_start2), .md_busy_o(md_busy2),
      .stall_cycles_o(stall_cnt2), .flush_count_o(flush_cnt2)
   );

   // {pc_stall, if_id_stall, if_id_flush, id_ex_hold, id_ex_bubble, id_ex_flush,
   //  ex_mem_bubble, md_start, md_busy}
   assign o1 = {pc_stall1, if_id_stall1, if_id_flush1, id_ex_hold1, id_ex_bubble1,
                id_ex_flush1, ex_mem_bubble1, md_start1, md_busy1};
   assign o2 = {pc_stall2, if_id_stall2, if_id_flush2, id_ex_hold2, id_ex_bubble2,
                id_ex_flush2, ex_mem_bubble2, md_start2, md_busy2};

   function automatic logic [8:0] model_out(input int lat, input int ph, input logic rn);
      logic lu;
      lu = mr && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      if (!rn) return 9'b0;
      if (ph == 0) begin
         if (rdr)     return 9'b001001000;  // both flushes
         else if (md) return 9'b110100110;  // stalls, hold, EX/MEM bubble, start
         else if (lu) return 9'b110010000;  // stalls, ID/EX bubble
         else         return 9'b0;
      end
      if (ph < lat) return 9'b110100101;    // still occupied: stalls + busy
      return 9'b000000001;                  // final occupancy cycle: busy only
   endfunction

   function automatic int next_ph(input int lat, input int ph);
      if (ph == 0) return (!rdr && md) ? 2 : 0;
      return (ph < lat) ? ph + 1 : 0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      rs1 = 0; rs2 = 0; rd = 0; u1 = 0; u2 = 0; mr = 0; md = 0; rdr = 0;
   endtask

   always @(posedge clk) begin
      if (!rst_n) begin
         ph1 <= 0; ph2 <= 0; m_stall <= 0; m_flush <= 0;
      end else begin
         e_pos = model_out(4, ph1, 1'b1);
         if (e_pos[8]) m_stall <= m_stall + 1;
         if (e_pos[6]) m_flush <= m_flush + 1;
         ph1 <= next_ph(4, ph1);
         ph2 <= next_ph(2, ph2);
      end
   end

   always @(negedge clk) begin
      chk("outs_lat4", {23'd0, o1}, {23'd0, model_out(4, ph1, rst_n)});
      chk("outs_lat2", {23'd0, o2}, {23'd0, model_out(2, ph2, rst_n)});
`ifdef HAZARD_STATS_EN
      chk("stall_cycles", stall_cnt1, m_stall);
      chk("flush_count", flush_cnt1, m_flush);
`else
      chk("stall_cycles_tied", stall_cnt1, 32'd0);
      chk("flush_count_tied", flush_cnt1, 32'd0);
`endif
      n_start += int'(md_start1);
      n_stall += int'(pc_stall1);
   end

   initial begin
      set_idle();
      rst_n = 1'b0;
      md = 1'b1;
      #1;
      chk("reset_all_zero", {23'd0, o1}, 32'd0);
      repeat (2) tick();
      rst_n = 1'b1; md = 1'b0;
      #1;
      chk("idle_after_reset", {23'd0, o1}, 32'd0);

      // Load-use through rs1
      tick(); mr = 1; rd = 5; rs1 = 5; u1 = 1; #1;
      chk("lu_pc_stall", {31'd0, pc_stall1}, 32'd1);
      chk("lu_if_id_stall", {31'd0, if_id_stall1}, 32'd1);
      chk("lu_bubble", {31'd0, id_ex_bubble1}, 32'd1);
      chk("lu_no_hold", {31'd0, id_ex_hold1}, 32'd0);
      // rd = x0 never hazards
      tick(); rd = 0; rs1 = 0; #1;
      chk("lu_rd0", {31'd0, pc_stall1}, 32'd0);
      // Match through rs2, then same match with rs2 unused
      tick(); rd = 7; rs1 = 3; rs2 = 7; u2 = 1; #1;
      chk("lu_rs2", {31'd0, pc_stall1}, 32'd1);
      tick(); u2 = 0; #1;
      chk("lu_rs2_unused", {31'd0, pc_stall1}, 32'd0);

      // Single MUL, latency 4
      tick(); set_idle(); n_start = 0; n_stall = 0; md = 1; #1;
      chk("mul_c1", {23'd0, o1}, 32'h1A6);
      tick(); #1;
      chk("mul_c2", {23'd0, o1}, 32'h1A5);
      tick(); rdr = 1; #1;   // redirect while busy must be ignored
      chk("mul_c3_redirect_ignored", {23'd0, o1}, 32'h1A5);
      tick(); rdr = 0; #1;
      chk("mul_c4_release", {23'd0, o1}, 32'h001);
      tick(); md = 0; #1;
      chk("mul_busy_low", {31'd0, md_busy1}, 32'd0);
      chk("mul_one_start", n_start, 32'd1);
      chk("mul_three_stalls", n_stall, 32'd3);

      // Back-to-back MUL
      n_start = 0; n_stall = 0; md = 1;
      repeat (4) tick(); #1;
      chk("b2b_second_start", {31'd0, md_start1}, 32'd1);
      repeat (4) tick(); md = 0; #1;
      chk("b2b_two_starts", n_start, 32'd2);
      chk("b2b_six_stalls", n_stall, 32'd6);

      // Redirect beats muldiv and load-use
      rdr = 1; md = 1; mr = 1; rd = 5; rs1 = 5; u1 = 1; #1;
      chk("redir_flushes", {23'd0, o1}, 32'h048);
      tick(); set_idle();

      // Reset during MD_BUSY
      md = 1;
      tick(); rst_n = 1'b0; #1;
      chk("rst_busy_zero", {23'd0, o1}, 32'd0);
      tick(); rst_n = 1'b1; md = 0; #1;
      chk("rst_back_to_run", {23'd0, o1}, 32'd0);
      n_stall = 0; md = 1;
      repeat (4) tick(); md = 0; #1;
      chk("rst_restart_full_stall", n_stall, 32'd3);

      // Statistics: one load-use, one MUL, two redirects
      tick(); rst_n = 1'b0; set_idle();
      tick(); rst_n = 1'b1;
      tick(); mr = 1; rd = 9; rs1 = 9; u1 = 1;
      tick(); set_idle(); md = 1;
      repeat (4) tick(); md = 0; rdr = 1;
      tick();
      tick(); set_idle(); #1;
`ifdef HAZARD_STATS_EN
      chk("stats_stalls", stall_cnt1, 32'd4);
      chk("stats_flushes", flush_cnt1, 32'd2);
`else
      chk("stats_stalls_off", stall_cnt1, 32'd0);
      chk("stats_flushes_off", flush_cnt1, 32'd0);
`endif
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
